// File: rtl/asyn_dual_8x16_ram_pkg.sv
// Shared defaults and types for the 8x16 simple dual-port RAM.
package asyn_dual_8x16_ram_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DATA_DEPTH = 8;
    localparam int DEF_DATA_ADDR  = 3;

    typedef logic [DEF_DATA_WIDTH-1:0] word_t;
    typedef logic [DEF_DATA_ADDR-1:0]  addr_t;

endpackage

// File: rtl/asyn_dual_8x16_ram_array.sv
// Storage array: one register per word so the synchronous clear can zero every word in one edge.
module asyn_dual_8x16_ram_array
    import asyn_dual_8x16_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DATA_DEPTH = DEF_DATA_DEPTH,
    parameter int DATA_ADDR  = DEF_DATA_ADDR
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  we,
    input  logic [DATA_ADDR-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic [DATA_ADDR-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_reg [DATA_DEPTH];

    generate
        for (genvar gi = 0; gi < DATA_DEPTH; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (clear) begin
                    mem_reg[gi] <= '0;
                end else if (we && (wr_addr == DATA_ADDR'(gi))) begin
                    mem_reg[gi] <= d_in;
                end
            end
        end
    endgenerate

    // Pre-write contents; the top decides whether to bypass on a collision.
    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/asyn_dual_8x16_ram.sv
// Simple dual-port RAM top: read register, collision handling and geometry check.
// Define RAM_WR_BYPASS_EN for write-first collisions; the default build is read-first.
module asyn_dual_8x16_ram
    import asyn_dual_8x16_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DATA_DEPTH = DEF_DATA_DEPTH,
    parameter int DATA_ADDR  = DEF_DATA_ADDR
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  we,
    input  logic [DATA_ADDR-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  re,
    input  logic [DATA_ADDR-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] d_out
);

    generate
        if (DATA_DEPTH != 2 ** DATA_ADDR) begin : g_bad_geometry
            $error("asyn_dual_8x16_ram: DATA_DEPTH must equal 2**DATA_ADDR");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] array_rd_data;
    logic [DATA_WIDTH-1:0] rd_word_next;
    logic [DATA_WIDTH-1:0] d_out_reg;

    asyn_dual_8x16_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .DATA_ADDR  (DATA_ADDR)
    ) u_array (
        .clk     (clk),
        .clear   (clear),
        .we      (we),
        .wr_addr (wr_addr),
        .d_in    (d_in),
        .rd_addr (rd_addr),
        .rd_data (array_rd_data)
    );

`ifdef RAM_WR_BYPASS_EN
    logic collision;
    assign collision = we && re && (wr_addr == rd_addr);

    always_comb begin
        rd_word_next = array_rd_data;
        if (collision) begin
            rd_word_next = d_in;
        end
    end
`else
    always_comb begin
        rd_word_next = array_rd_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            d_out_reg <= '0;
        end else if (re) begin
            d_out_reg <= rd_word_next;
        end
    end

    assign d_out = d_out_reg;

endmodule

// File: tb/tb_asyn_dual_8x16_ram.sv
// Directed bench for asyn_dual_8x16_ram: behavioural memory model plus literal checkpoints.
module tb_asyn_dual_8x16_ram;
    import asyn_dual_8x16_ram_pkg::*;

`ifdef RAM_WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic  clk = 1'b0;
    logic  clear = 1'b0;
    logic  we = 1'b0;
    addr_t wr_addr = '0;
    word_t d_in = '0;
    logic  re = 1'b0;
    addr_t rd_addr = '0;
    word_t d_out;

    int vectors = 0;
    int miscompares = 0;

    word_t model_mem [8];
    word_t model_dout = '0;
    bit    model_valid = 1'b0;
    bit    done = 1'b0;

    always #5 clk = ~clk;

    asyn_dual_8x16_ram dut (
        .clk     (clk),
        .clear   (clear),
        .we      (we),
        .wr_addr (wr_addr),
        .d_in    (d_in),
        .re      (re),
        .rd_addr (rd_addr),
        .d_out   (d_out)
    );

    // Reference: RAM semantics applied at each rising edge.
    always @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < 8; i++) model_mem[i] = '0;
            model_dout  = '0;
            model_valid = 1'b1;
        end else begin
            if (re) begin
                if (BYPASS && we && (wr_addr == rd_addr)) model_dout = d_in;
                else                                      model_dout = model_mem[rd_addr];
            end
            if (we) model_mem[wr_addr] = d_in;
        end
    end

    always @(negedge clk) begin
        if (model_valid && !done) begin
            vectors++;
            if (d_out !== model_dout) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t d_out=%h expected=%h", $time, d_out, model_dout);
            end
        end
    end

    task automatic op(input logic c, input logic w, input int wa, input word_t din,
                      input logic r, input int ra);
        @(negedge clk);
        clear   = c;
        we      = w;
        wr_addr = addr_t'(wa);
        d_in    = din;
        re      = r;
        rd_addr = addr_t'(ra);
        @(posedge clk);
        #1;
        $display("op clear=%0b we=%0b wa=%0d din=%h re=%0b ra=%0d -> d_out=%h",
                 c, w, wa, din, r, ra, d_out);
    endtask

    task automatic lit(input string name, input word_t exp);
        vectors++;
        if (d_out !== exp) begin
            miscompares++;
            $display("FAIL %s d_out=%h expected=%h", name, d_out, exp);
        end
    endtask

    initial begin
        op(1, 0, 0, 16'h0000, 0, 0);
        op(1, 0, 0, 16'h0000, 0, 0);
        lit("reset_dout", 16'h0000);
        for (int i = 0; i < 8; i++) begin
            op(0, 0, 0, 16'h0000, 1, i);
            lit("read_after_clear", 16'h0000);
        end

        op(0, 1, 7, 16'h1111, 0, 0);
        op(0, 0, 0, 16'h0000, 1, 7);
        lit("read7", 16'h1111);

        op(0, 1, 4, 16'hFFFF, 0, 0);
        op(0, 1, 5, 16'h1010, 0, 0);
        op(0, 0, 0, 16'h0000, 1, 4);
        lit("read4", 16'hFFFF);
        op(0, 0, 0, 16'h0000, 1, 5);
        lit("read5", 16'h1010);
        op(0, 0, 0, 16'h0000, 1, 7);
        lit("read7_again", 16'h1111);

        op(0, 0, 0, 16'h0000, 1, 4);
        lit("read4_hold_start", 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            op(0, 1, 4, 16'hABCD, 0, 4);
            lit("re_low_hold", 16'hFFFF);
        end
        op(0, 0, 0, 16'h0000, 1, 4);
        lit("read4_new", 16'hABCD);

        op(0, 0, 0, 16'h0000, 1, 7);
        lit("pre_collision", 16'h1111);
        op(0, 1, 7, 16'h2222, 1, 7);
        lit("collision", BYPASS ? 16'h2222 : 16'h1111);
        op(0, 0, 0, 16'h0000, 1, 7);
        lit("post_collision", 16'h2222);

        op(0, 1, 2, 16'h0F0F, 1, 2);
        lit("collision_addr2", BYPASS ? 16'h0F0F : 16'h0000);
        op(0, 1, 3, 16'h3333, 1, 2);
        lit("read2_diff_write", 16'h0F0F);

        op(1, 1, 5, 16'h5555, 1, 5);
        lit("clear_priority", 16'h0000);
        op(0, 0, 0, 16'h0000, 1, 5);
        lit("read5_after_clear", 16'h0000);
        op(0, 0, 0, 16'h0000, 1, 7);
        lit("read7_after_clear", 16'h0000);

        @(negedge clk);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
